xup_debounce6: RTL and testbench

- Six-channel synchronizer and debouncer for raw Basys3 push-buttons and switches.
- Produces clean, glitch-free levels and one-cycle edge pulses.
- Sits directly upstream of xup_or6: db[5:0] drives that gate's a..f inputs to form a clean "any input active" signal.
- Channels are fully independent; a shared change strobe is provided for polling logic.

---
 rtl/xup_debounce6_pkg.sv | 19 +
 rtl/xup_debounce6_ch.sv | 53 +++++
 rtl/xup_debounce6.sv | 48 ++++
 tb/tb_xup_debounce6.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/xup_debounce6_pkg.sv
// Shared constants and the counter-width helper for the six-channel debouncer.
// The helper backs the elaboration-time sizing check in the top.
package xup_debounce_pkg;

  localparam int NUM_CH                = 6;
  localparam int DEFAULT_STABLE_CYCLES = 1000000;
  localparam int MAX_STABLE_CYCLES     = (1 << 24) - 1;

  // Smallest w with 2^w > n, i.e. enough bits to hold the value n.
  function automatic int min_cnt_w(input int n);
    int w;
    w = 1;
    for (int i = 0; i < 31; i++) begin
      if ((longint'(1) << w) <= longint'(n)) w++;
    end
    return w;
  endfunction

endpackage

// File: rtl/xup_debounce6_ch.sv
// One debounce channel: two-flop synchronizer, stability counter and
// registered level/edge outputs. flip is the combinational "db updates now" term.
module xup_debounce_ch
  import xup_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall,
  output logic flip
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;

  assign mismatch = s2 ^ db;
  assign flip     = mismatch && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      cnt  <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= flip & s2;
      fall <= flip & ~s2;
      // Any agreement with db discards the partial count, so short glitches never land.
      if (!mismatch) begin
        cnt <= '0;
      end else if (flip) begin
        cnt <= '0;
        db  <= s2;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/xup_debounce6.sv
// Six independent debounce channels for Basys3 buttons/switches, plus a
// registered strobe that pulses whenever any channel's level changes.
module xup_debounce6
  import xup_debounce_pkg::*;
#(
  parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int CNT_W         = 24
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   raw,
  output logic [NUM_CH-1:0]   db,
  output logic [NUM_CH-1:0]   rise,
  output logic [NUM_CH-1:0]   fall,
  output logic                changed
);

  if (STABLE_CYCLES < 1 || STABLE_CYCLES > MAX_STABLE_CYCLES) begin : g_bad_stable
    $fatal(1, "xup_debounce6: STABLE_CYCLES out of range 1..2^24-1");
  end
  if (CNT_W < min_cnt_w(STABLE_CYCLES)) begin : g_bad_cnt_w
    $fatal(1, "xup_debounce6: CNT_W too narrow for STABLE_CYCLES");
  end

  logic [NUM_CH-1:0] flip;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    xup_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .db   (db[i]),
      .rise (rise[i]),
      .fall (fall[i]),
      .flip (flip[i])
    );
  end

  // Registered from the same flip terms that load rise/fall, so it lines up with them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) changed <= 1'b0;
    else       changed <= |flip;
  end

endmodule

// File: tb/tb_xup_debounce6.sv
// Directed bench for xup_debounce6 with STABLE_CYCLES=4: power-up, single edges,
// glitch rejection, bouncing input, simultaneous falls and reset mid-count.
module tb_xup_debounce6;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] raw = 6'b0;
  logic [5:0] db;
  logic [5:0] rise;
  logic [5:0] fall;
  logic       changed;

  int total = 0;
  int bad   = 0;

  xup_debounce6 #(
    .STABLE_CYCLES(4),
    .CNT_W        (3)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .raw    (raw),
    .db     (db),
    .rise   (rise),
    .fall   (fall),
    .changed(changed)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    raw = 6'b111111;
    #1 reset = 1'b1;
    #2;
    total++;
    if (db !== 6'b0 || rise !== 6'b0 || fall !== 6'b0 || changed !== 1'b0) begin
      bad++;
      $display("FAIL reset_async: db=%b rise=%b fall=%b changed=%b, want all 0", db, rise, fall, changed);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (db !== 6'b0 || rise !== 6'b0 || fall !== 6'b0 || changed !== 1'b0) begin
        bad++;
        $display("FAIL reset_held %0d: db=%b rise=%b fall=%b changed=%b, want all 0", i, db, rise, fall, changed);
      end
    end
    reset = 1'b0;
  endtask

  // raw=111111 since reset; the first edge after release is the first sampled edge.
  task automatic test_power_up();
    logic [5:0] e_db, e_rise;
    logic       e_ch;
    for (int i = 1; i <= 7; i++) begin
      tick();
      e_db   = (i >= 6) ? 6'b111111 : 6'b0;
      e_rise = (i == 6) ? 6'b111111 : 6'b0;
      e_ch   = (i == 6);
      total++;
      if (db !== e_db || rise !== e_rise || fall !== 6'b0 || changed !== e_ch) begin
        bad++;
        $display("FAIL power_up t%0d: db=%b rise=%b fall=%b changed=%b, want db=%b rise=%b fall=000000 changed=%b",
                 i, db, rise, fall, changed, e_db, e_rise, e_ch);
      end
    end
  endtask

  task automatic test_all_fall();
    logic [5:0] e_db, e_fall;
    logic       e_ch;
    raw = 6'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      e_db   = (i >= 6) ? 6'b0 : 6'b111111;
      e_fall = (i == 6) ? 6'b111111 : 6'b0;
      e_ch   = (i == 6);
      total++;
      if (db !== e_db || rise !== 6'b0 || fall !== e_fall || changed !== e_ch) begin
        bad++;
        $display("FAIL all_fall t%0d: db=%b rise=%b fall=%b changed=%b, want db=%b rise=000000 fall=%b changed=%b",
                 i, db, rise, fall, changed, e_db, e_fall, e_ch);
      end
    end
  endtask

  task automatic test_single_rise();
    logic [5:0] e_db, e_rise;
    logic       e_ch;
    raw = 6'b000100;
    for (int i = 1; i <= 7; i++) begin
      tick();
      e_db   = (i >= 6) ? 6'b000100 : 6'b0;
      e_rise = (i == 6) ? 6'b000100 : 6'b0;
      e_ch   = (i == 6);
      total++;
      if (db !== e_db || rise !== e_rise || fall !== 6'b0 || changed !== e_ch) begin
        bad++;
        $display("FAIL single_rise t%0d: db=%b rise=%b fall=%b changed=%b, want db=%b rise=%b fall=000000 changed=%b",
                 i, db, rise, fall, changed, e_db, e_rise, e_ch);
      end
    end
  endtask

  // raw[0] high for 3 cycles is one short of the 4-cycle threshold.
  task automatic test_glitch();
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < 6; i++) begin
        raw = (i < 3) ? 6'b000101 : 6'b000100;
        tick();
        total++;
        if (db !== 6'b000100 || rise !== 6'b0 || fall !== 6'b0 || changed !== 1'b0) begin
          bad++;
          $display("FAIL glitch r%0d t%0d: db=%b rise=%b fall=%b changed=%b, want db=000100 no edges",
                   r, i, db, rise, fall, changed);
        end
      end
    end
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic test_bounce();
    logic [5:0] e_db, e_rise;
    logic       e_ch;
    int         pulses;
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      raw = (i % 2 == 0) ? 6'b100100 : 6'b000100;
      tick();
      if (rise[5] === 1'b1) pulses++;
      total++;
      if (db !== 6'b000100 || changed !== 1'b0) begin
        bad++;
        $display("FAIL bounce_phase t%0d: db=%b changed=%b, want db=000100 changed=0", i, db, changed);
      end
    end
    raw = 6'b100100;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (rise[5] === 1'b1) pulses++;
      e_db   = (i >= 6) ? 6'b100100 : 6'b000100;
      e_rise = (i == 6) ? 6'b100000 : 6'b0;
      e_ch   = (i == 6);
      total++;
      if (db !== e_db || rise !== e_rise || fall !== 6'b0 || changed !== e_ch) begin
        bad++;
        $display("FAIL bounce_settle t%0d: db=%b rise=%b fall=%b changed=%b, want db=%b rise=%b fall=000000 changed=%b",
                 i, db, rise, fall, changed, e_db, e_rise, e_ch);
      end
    end
    total++;
    if (pulses !== 1) begin
      bad++;
      $display("FAIL bounce_pulse_count: got %0d rise[5] pulses, want 1", pulses);
    end
  endtask

  task automatic test_simul_fall();
    logic [5:0] e_db, e_fall;
    logic       e_ch;
    int         ch_pulses;
    raw = 6'b110110;
    for (int i = 1; i <= 7; i++) tick();
    total++;
    if (db !== 6'b110110) begin
      bad++;
      $display("FAIL simul_setup: db=%b, want 110110", db);
    end
    raw = 6'b100100;
    ch_pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (changed === 1'b1) ch_pulses++;
      e_db   = (i >= 6) ? 6'b100100 : 6'b110110;
      e_fall = (i == 6) ? 6'b010010 : 6'b0;
      e_ch   = (i == 6);
      total++;
      if (db !== e_db || rise !== 6'b0 || fall !== e_fall || changed !== e_ch) begin
        bad++;
        $display("FAIL simul_fall t%0d: db=%b rise=%b fall=%b changed=%b, want db=%b rise=000000 fall=%b changed=%b",
                 i, db, rise, fall, changed, e_db, e_fall, e_ch);
      end
    end
    total++;
    if (ch_pulses !== 1) begin
      bad++;
      $display("FAIL simul_changed_count: got %0d changed pulses, want 1", ch_pulses);
    end
  endtask

  // Four edges after raw[0] goes high the channel counter sits at 2; reset lands between edges.
  task automatic test_reset_mid();
    logic [5:0] e_db, e_rise;
    logic       e_ch;
    raw = 6'b100101;
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (db !== 6'b100100) begin
      bad++;
      $display("FAIL reset_mid_pre: db=%b, want 100100", db);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (db !== 6'b0 || rise !== 6'b0 || fall !== 6'b0 || changed !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_async: db=%b rise=%b fall=%b changed=%b, want all 0", db, rise, fall, changed);
    end
    tick();
    reset = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick();
      e_db   = (i >= 6) ? 6'b100101 : 6'b0;
      e_rise = (i == 6) ? 6'b100101 : 6'b0;
      e_ch   = (i == 6);
      total++;
      if (db !== e_db || rise !== e_rise || fall !== 6'b0 || changed !== e_ch) begin
        bad++;
        $display("FAIL reset_mid_redo t%0d: db=%b rise=%b fall=%b changed=%b, want db=%b rise=%b fall=000000 changed=%b",
                 i, db, rise, fall, changed, e_db, e_rise, e_ch);
      end
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_all_fall();
    test_single_rise();
    test_glitch();
    test_bounce();
    test_simul_fall();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
